// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int          ITER    = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Odd encodings (MULTU, DIVU) are the unsigned variants.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_absneg.sv
// Combinational conditional two's-complement negate, used for operand
// magnitudes and for the final sign correction of results.
module muldiv_absneg #(
    parameter int WIDTH = 32
) (
    input  logic             en,
    input  logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] out_val
);

    always_comb begin
        out_val = en ? (~in_val + WIDTH'(1)) : in_val;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit producing {HI,LO}.
// Optional single-cycle multiply enabled by defining MULDIV_FAST_MULT_EN.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [63:0] result
);

    state_e      state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic        is_div_q,  is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q,    div0_d;
    logic [31:0] opnd_q,    opnd_d;
    logic [63:0] acc_q,     acc_d;
    logic [63:0] result_q,  result_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;

    logic        sign_a, sign_b;
    logic [31:0] abs_a, abs_b;
    logic        idle_or_done;

    assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign sign_a       = op_is_signed(op) & a[31];
    assign sign_b       = op_is_signed(op) & b[31];

    muldiv_absneg #(.WIDTH(32)) u_abs_a (.en(sign_a), .in_val(a), .out_val(abs_a));
    muldiv_absneg #(.WIDTH(32)) u_abs_b (.en(sign_b), .in_val(b), .out_val(abs_b));

    // Multiply step: conditional add into the high half, then shift right.
    // acc holds {partial_product_hi, remaining_multiplier_bits}.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Restoring divide step: acc holds {remainder, dividend/quotient bits}.
    logic [32:0] div_shift, div_diff;
    logic [63:0] div_next;
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                    : {div_diff[31:0],  acc_q[30:0], 1'b1};

    // Product sign fix source: the single-cycle multiplier in the start
    // cycle, otherwise the iterated accumulator.
    logic [63:0] prod_src, prod_fixed;
    logic        prod_neg;
`ifdef MULDIV_FAST_MULT_EN
    assign prod_src = idle_or_done ? ({32'd0, abs_a} * {32'd0, abs_b}) : acc_q;
    assign prod_neg = idle_or_done ? (sign_a ^ sign_b) : neg_res_q;
`else
    assign prod_src = acc_q;
    assign prod_neg = neg_res_q;
`endif

    logic [31:0] quot_fixed, rem_fixed;
    muldiv_absneg #(.WIDTH(64)) u_fix_prod (.en(prod_neg),  .in_val(prod_src),     .out_val(prod_fixed));
    muldiv_absneg #(.WIDTH(32)) u_fix_quot (.en(neg_res_q), .in_val(acc_q[31:0]),  .out_val(quot_fixed));
    // Divide-by-zero leaves |a| in the remainder, so this restores HI = a.
    muldiv_absneg #(.WIDTH(32)) u_fix_rem  (.en(neg_rem_q), .in_val(acc_q[63:32]), .out_val(rem_fixed));

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end else if (start) begin
                    is_div_d  = op_is_div(op);
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    div0_d    = (b == 32'd0);
                    opnd_d    = op_is_div(op) ? abs_b : abs_a;
                    acc_d     = {32'd0, op_is_div(op) ? abs_a : abs_b};
                    cnt_d     = 5'd0;
                    state_d   = ST_RUN;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
`ifdef MULDIV_FAST_MULT_EN
                    if (!op_is_div(op)) begin
                        state_d  = ST_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        result_d = prod_fixed;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(ITER - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (is_div_q) begin
                        result_d = {rem_fixed, div0_q ? DIV0_LO : quot_fixed};
                    end else begin
                        result_d = prod_fixed;
                    end
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            opnd_q    <= 32'd0;
            acc_q     <= 64'd0;
            result_q  <= 64'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign stall  = busy_q | (start & idle_or_done);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected results,
// a negedge monitor pops and compares on each rising done.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [63:0] result;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    typedef struct {
        string       name;
        logic [63:0] result;
        int          edges;
        int          issue_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Edges between the start edge and done: 33 for the iterative path.
    function automatic int done_edges(input logic [1:0] o);
`ifdef MULDIV_FAST_MULT_EN
        return o[1] ? 33 : 0;
`else
        return 33;
`endif
    endfunction

    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [63:0] exp, input bit push);
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) sb_q.push_back('{name: name, result: exp, edges: done_edges(o), issue_cyc: cyc});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 64'(n < 100), 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && done && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_result"}, result, e.result);
                check({e.name, "_latency"}, 64'(cyc - e.issue_cyc), 64'(e.edges));
            end
        end
        done_prev = done;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        #12;
        check("rst_busy",   64'(busy),   64'd0);
        check("rst_done",   64'(done),   64'd0);
        check("rst_result", result,      64'd0);
        check("rst_stall",  64'(stall),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1);
`ifdef MULDIV_FAST_MULT_EN
        check("fast_busy",  64'(busy),  64'd0);
        check("fast_done",  64'(done),  64'd1);
        check("fast_stall", 64'(stall), 64'd0);
`else
        check("run_busy",  64'(busy),  64'd1);
        check("run_stall", 64'(stall), 64'd1);
        repeat (32) @(posedge clk);
        #1;
        check("fix_busy", 64'(busy), 64'd1);
        check("fix_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        check("done_busy", 64'(busy), 64'd0);
        check("done_done", 64'(done), 64'd1);
`endif
        wait_done("multu_max");

        issue("mult_neg3x7", MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1);
        wait_done("mult_neg3x7");
        issue("mult_minxmin", MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1);
        wait_done("mult_minxmin");
        issue("multu_shift", MULTU, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780, 1);
        wait_done("multu_shift");

        issue("div_neg7_2", DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1);
        wait_done("div_neg7_2");
        issue("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1);
        wait_done("div_min_m1");
        issue("div_7_neg2", DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1);
        wait_done("div_7_neg2");
        issue("div_neg100_0", DIV, 32'hFFFF_FF9C, 32'd0, 64'hFFFF_FF9C_FFFF_FFFF, 1);
        wait_done("div_neg100_0");

        // Second start during RUN must be ignored.
        issue("divu_100_0", DIVU, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1);
        repeat (5) @(posedge clk);
        issue("ignored", MULTU, 32'd3, 32'd3, 64'd0, 0);
        check("ignored_busy", 64'(busy), 64'd1);
        wait_done("divu_100_0");

        issue("divu_50_5", DIVU, 32'd50, 32'd5, 64'h0000_0000_0000_000A, 1);
        wait_done("divu_50_5");

        // Flush on the 10th RUN edge.
        issue("flushed", DIVU, 32'd99, 32'd3, 64'd0, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy",   64'(busy), 64'd0);
        check("flush_done",   64'(done), 64'd0);
        check("flush_result", result,    64'h0000_0000_0000_000A);
        repeat (3) @(negedge clk);
        check("flush_no_done", 64'(done),  64'd0);
        check("flush_stall",   64'(stall), 64'd0);

        issue("divu_99_3", DIVU, 32'd99, 32'd3, 64'h0000_0000_0000_0021, 1);
        wait_done("divu_99_3");

        // Flush in DONE clears done but keeps result.
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_done_state", 64'(done), 64'd0);
        check("flush_keep_result", result, 64'h0000_0000_0000_0021);

        // Flush and start together: start is dropped.
        @(negedge clk);
        op = DIVU; a = 32'd1; b = 32'd1; start = 1'b1; flush = 1'b1;
        #1;
        check("flush_start_stall", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_start_no_done", 64'(done), 64'd0);

        // Asynchronous reset mid-operation.
        issue("reset_victim", DIVU, 32'd1000, 32'd7, 64'd0, 0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",   64'(busy),  64'd0);
        check("arst_done",   64'(done),  64'd0);
        check("arst_result", result,     64'd0);
        check("arst_stall",  64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("divu_1000_7", DIVU, 32'd1000, 32'd7, 64'h0000_0006_0000_008E, 1);
        wait_done("divu_1000_7");

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative 32-bit multiply/divide unit in the EX stage for MULT, MULTU, DIV and DIVU.
- Produces the 64-bit {HI,LO} value that the EX/MEM pipeline register carries as ex_mult.
- Asserts stall so the front of the pipeline holds while an operation is in flight.
- Flushable on exception or branch squash.

Parameters:
- ITER, 32, iterations per operation; equals the operand width, which is fixed at 32.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only when idle or done.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  rs operand (multiplicand or dividend).
- b  in  32  rt operand (multiplier or divisor).
- flush  in  1  abort the in-flight operation.
- busy  out  1  operation in progress.
- stall  out  1  combinational pipeline hold.
- done  out  1  result valid.
- result  out  64  [63:32] = HI, [31:0] = LO.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: state = IDLE; busy, done and result all 0; counter 0.
- States: IDLE, RUN, FIX, DONE.
  - IDLE/DONE with start=1 at edge E0: latch |a| and |b| (magnitudes for signed ops, raw values for unsigned), the sign flags and op; counter = 0; go to RUN. done drops.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. After the step with counter = ITER-1 (edge E32), go to FIX.
  - FIX (edge E33): apply sign correction, register result, go to DONE.
  - DONE: done = 1; result held stable until the next accepted start.
- Latency: done is first high after edge E33, i.e. 33 edges after start was sampled.
- busy = 1 in RUN and FIX.
- stall = busy | (start & (state==IDLE | state==DONE)).
- Multiply:
  - Signed product = negate(|a|*|b|) when a[31] xor b[31].
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - LO = quotient, HI = remainder.
  - Signed: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Divide by zero (both signed and unsigned): LO = 0xFFFFFFFF, HI = a. done asserts at the normal time.
- start while busy: ignored; the operation in progress is unaffected.
- flush while busy: state = IDLE at the next edge; done is not asserted; result keeps its previous value.
- flush in DONE: clears done.
- flush and start together: flush wins; start is dropped.
- rst_n low mid-operation: immediate return to reset values.

Optional Feature:
MULDIV_FAST_MULT_EN
- Defined: MULT/MULTU go from IDLE/DONE straight to DONE at E0. The full product is computed in a single cycle, so done is high after E0 (latency 1) and busy never asserts for multiplies. stall is high only in the start cycle. Divides are unchanged.
- Undefined: multiplies use the 33-edge iterative path, identical to divides.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encoding ST_IDLE, ST_RUN, ST_FIX, ST_DONE;
  - constant ITER = 32;
  - constant DIV0_LO = 32'hFFFFFFFF.
- One sub-module, muldiv_absneg: combinational conditional two's-complement negate (a width parameter and an enable input). It is instantiated for operand magnitudes and for quotient, remainder and product sign fix.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFE_00000001; done first high after edge 33; busy high for edges 1-33.
- MULT a=0xFFFFFFFD (-3), b=7 -> result 0xFFFFFFFF_FFFFFFEB; with MULDIV_FAST_MULT_EN, same value with done after 1 edge.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO 0x80000000, HI 0.
- DIVU a=100, b=0 -> LO 0xFFFFFFFF, HI 0x00000064. A second start during RUN is ignored, and the first result is still correct.
- DIVU 50/5 completes (result LO 0x0000000A, HI 0); then a new DIVU is started and flushed on its 10th RUN edge -> busy low next edge, no done, result still 0x00000000_0000000A. A start in the following cycle is accepted and completes normally.
- rst_n pulsed low mid-RUN -> busy, done and result are 0 asynchronously; stall = 0 with start low.
